// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator datapath blocks.
// Holds default tile geometry, the drain FSM state type and small sizing helpers.
package cnn_accel_pkg;

  localparam int unsigned TN_DEF     = 8;
  localparam int unsigned TR_DEF     = 16;
  localparam int unsigned TC_DEF     = 8;
  localparam int unsigned TILE_WORDS = TN_DEF * TR_DEF * TC_DEF;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  function automatic int unsigned tile_words(input int unsigned tn, input int unsigned tr,
                                             input int unsigned tc);
    return tn * tr * tc;
  endfunction

  // Bit width needed to index v entries, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/nest3_counter.sv
// Three-level nested counter: n0 fastest, wrapping at N0_MAX, then n1, then n2.
// Synchronous clear has priority over enable.
module nest3_counter #(
  parameter int unsigned CW     = 32,
  parameter int unsigned N0_MAX = 8,
  parameter int unsigned N1_MAX = 16,
  parameter int unsigned N2_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clean,
  input  logic          i_ena,
  output logic [CW-1:0] o_n0,
  output logic [CW-1:0] o_n1,
  output logic [CW-1:0] o_n2
);

  logic [CW-1:0] r_n0, r_n1, r_n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n0 <= '0;
      r_n1 <= '0;
      r_n2 <= '0;
    end else if (i_clean) begin
      r_n0 <= '0;
      r_n1 <= '0;
      r_n2 <= '0;
    end else if (i_ena) begin
      if (r_n0 == CW'(N0_MAX - 1)) begin
        r_n0 <= '0;
        if (r_n1 == CW'(N1_MAX - 1)) begin
          r_n1 <= '0;
          r_n2 <= (r_n2 == CW'(N2_MAX - 1)) ? '0 : r_n2 + CW'(1);
        end else begin
          r_n1 <= r_n1 + CW'(1);
        end
      end else begin
        r_n0 <= r_n0 + CW'(1);
      end
    end
  end

  assign o_n0 = r_n0;
  assign o_n1 = r_n1;
  assign o_n2 = r_n2;

endmodule

// File: rtl/out_fm_skid2.sv
// Two-entry FIFO that absorbs the tile buffer's read latency.
// Head data is driven straight from the storage register.
module out_fm_skid2 #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr, r_rd_ptr;
  logic [1:0]    r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_wr, i_rd})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/out_fm_buf_to_fifo.sv
// Drains one Tn x Tr x Tc output tile from the tile buffer into the out_fm FIFO,
// one word per cycle when the FIFO has room, in tc/tr/tn order.
module out_fm_buf_to_fifo
  import cnn_accel_pkg::*;
#(
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned Tn = 8,
  parameter int unsigned Tr = 16,
  parameter int unsigned Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          buf_rd_ena,
  output logic [AW-1:0] buf_rd_addr,
  input  logic [DW-1:0] data_from_buf,
  output logic          fifo_push,
  input  logic          fifo_full,
  output logic [DW-1:0] data_to_fifo
);

  localparam int unsigned TOTAL = tile_words(Tn, Tr, Tc);

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_rd_cnt, r_push_cnt;
  logic          r_inflight;
  logic [1:0]    w_occ;
  logic [2:0]    w_pend;
  logic          w_start_ok;
  logic [CW-1:0] w_n0, w_n1, w_n2;

  assign w_start_ok = (r_state == IDLE) && start;

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    busy        = (r_state != IDLE);
    fifo_push   = (w_occ != 2'd0) && !fifo_full;
    // Words held or in flight after this cycle; must stay below the skid depth.
    w_pend      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, fifo_push};
    buf_rd_ena  = (r_state == RUN) && (r_rd_cnt < CW'(TOTAL)) && (w_pend < 3'd2);
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (fifo_push && (r_push_cnt == CW'(TOTAL - 1))) w_state_nxt = FINISH;
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_cnt   <= '0;
      r_push_cnt <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= buf_rd_ena;
      if (w_start_ok) begin
        r_rd_cnt   <= '0;
        r_push_cnt <= '0;
      end else begin
        if (buf_rd_ena) r_rd_cnt <= r_rd_cnt + CW'(1);
        if (fifo_push)  r_push_cnt <= r_push_cnt + CW'(1);
      end
    end
  end

  nest3_counter #(
    .CW     (CW),
    .N0_MAX (Tc),
    .N1_MAX (Tr),
    .N2_MAX (Tn)
  ) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clean (w_start_ok),
    .i_ena   (buf_rd_ena),
    .o_n0    (w_n0),
    .o_n1    (w_n1),
    .o_n2    (w_n2)
  );

  assign buf_rd_addr = AW'(w_n2 * CW'(Tr * Tc) + w_n1 * CW'(Tc) + w_n0);

  out_fm_skid2 #(
    .DW (DW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_inflight),
    .i_wdata (data_from_buf),
    .i_rd    (fifo_push),
    .o_head  (data_to_fifo),
    .o_occ   (w_occ)
  );

endmodule

// File: doc/out_fm_buf_to_fifo.md
Name: out_fm_buf_to_fifo

Overview:
Drains one completed output-feature-map tile (Tn x Tr x Tc words) from the on-chip out_fm tile buffer into the out_fm FIFO. The downstream FIFO-to-RAM mover then scatters it into the off-chip image.
- Read order is tc fastest, then tr, then tn, matching the downstream consumer's counter order.
- Runs at full rate (one word per cycle) when the FIFO has room.
- Absorbs the buffer's 1-cycle read latency with a 2-entry skid buffer.

Parameters:
CW, 32, counter width
AW, 16, buffer address width
DW, 32, data width
Tn, 8, tile depth (output channels)
Tr, 16, tile rows
Tc, 8, tile columns

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begin draining a tile
done  out  1  one-cycle pulse after the last word is pushed
busy  out  1  high from the cycle after an accepted start until done, inclusive
buf_rd_ena  out  1  buffer read strobe
buf_rd_addr  out  AW  buffer read address
data_from_buf  in  DW  buffer read data, valid the cycle after buf_rd_ena
fifo_push  out  1  FIFO write strobe
fifo_full  in  1  FIFO full; push is not allowed while high
data_to_fifo  out  DW  data written with fifo_push

Behaviour:
- Reset is rst, asynchronous and active-high; clock is clk. All state clears on reset.
  - done, busy, buf_rd_ena and fifo_push reset to 0.
  - buf_rd_addr and data_to_fifo reset to 0.
  - Skid buffer, counters and in-flight flag clear.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN on start.
  - RUN -> FINISH when all TOTAL = Tn*Tr*Tc words have been pushed.
  - FINISH -> IDLE unconditionally after one cycle; done=1 only in FINISH.
  - start outside IDLE is ignored. start in the same cycle as done (FINISH) is ignored.
- Read address: buf_rd_addr = tn*Tr*Tc + tr*Tc + tc, computed from the read counter and truncated to AW.
  - The read counter advances on each buf_rd_ena, wrapping tc at Tc, tr at Tr and tn at Tn.
- In-flight flag: set in the cycle buf_rd_ena=1; in the next cycle data_from_buf is written into the skid buffer and the flag clears.
- Read issue rule: buf_rd_ena = RUN && reads_issued < TOTAL && (occ + inflight - push_now) < 2.
  - occ is skid occupancy (0..2).
  - push_now is this cycle's fifo_push.
  - This guarantees the skid buffer never overflows.
- Push rule: fifo_push = (occ > 0) && !fifo_full.
  - data_to_fifo = skid head, driven combinationally from the skid register.
  - Order is strictly preserved.
- Latency: start at cycle 0 gives RUN and the first buf_rd_ena in cycle 1, and the first fifo_push in cycle 3 (if not full).
  - Steady state with fifo_full=0 is one push per cycle.
  - The last push is in cycle TOTAL+2; done is in cycle TOTAL+3.
- fifo_full rising mid-stream: pushes stop immediately. At most 2 words are held (occ=2), after which reads stop. Pushes resume the cycle fifo_full falls, with no loss or duplication.
- Simultaneous skid write and push in the same cycle: occ is unchanged and the head advances.
- Counters count exactly TOTAL reads and pushes; no extra read past the tile end.
- busy drops the cycle after done.
- Reset mid-operation aborts the drain; no done is produced.

Decomposition:
- Shared package (cnn_accel_pkg) holds:
  - TILE_WORDS = Tn*Tr*Tc
  - the FSM state enum {IDLE, RUN, FINISH}
  - width helper functions
- Reuse nest3_counter (n0_max=Tc, n1_max=Tr, n2_max=Tn) as the read-address counter. ena = buf_rd_ena; clean = start accepted in IDLE.
- Sub-module out_fm_skid2: 2-entry FIFO with occ output. Its write port is fed by the in-flight flag and data_from_buf; its read port is fifo_push.

Test Plan:
- Tn=2,Tr=3,Tc=4, buffer[i]=i, fifo_full=0, start pulse:
  - 24 pushes on consecutive cycles 3..26 carrying 0..23 in order;
  - done only in cycle 27;
  - busy high in cycles 1..27.
- Same config, fifo_full held high in cycles 5..9:
  - no push in 5..9;
  - buf_rd_ena low once occ=2;
  - stream resumes at cycle 10 with the next value and no gap or duplicate;
  - done 5 cycles later than the no-stall run.
- Random fifo_full (50%), defaults Tn=8,Tr=16,Tc=8:
  - exactly 1024 pushes of values 0..1023 in order;
  - occ never exceeds 2;
  - read address never exceeds 1023.
- start re-pulsed in cycles 5 and 27 (done cycle): ignored; exactly one done and 24 pushes.
- rst asserted in cycle 10 mid-drain:
  - all outputs are 0 in the same cycle;
  - no done;
  - a subsequent start drains a fresh full tile starting at address 0.
- Back-to-back tiles, start in the cycle after done: the second tile starts at address 0 with identical timing to the first.
